// File: rtl/pipelined_addsub_if.sv
// Valid/ready operand and result bundle for pipelined_addsub.
// master = producer of operands and consumer of results; slave = the adder.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: carry chain cut into STAGES segments, one per register stage.
// Global-stall valid/ready pipe with registered sum and ALU flags (cout, ovf, zero, neg).
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              reset,
    pipelined_addsub_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int MSB  = WIDTH - 1;
    localparam int LAST = STAGES - 1;

    logic             adv;
    logic             c0;
    logic             c_msb;

    // Stage k holds operands plus the result segments below segment k.
    logic             pv [STAGES];
    logic [WIDTH-1:0] pa [STAGES];
    logic [WIDTH-1:0] pb [STAGES];
    logic [WIDTH-1:0] ps [STAGES];
    logic             pc [STAGES];
    logic             pz [STAGES];

    logic [SEG:0]     seg [STAGES];
    logic [WIDTH-1:0] ns  [STAGES];
    logic             nz  [STAGES];

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv || reset;
    assign bus.out_valid = out_valid_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.ovf      = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.neg      = neg_q;

    always_comb begin
        c0 = bus.cin;
        case (bus.op)
            2'b00:   c0 = 1'b0;
            2'b01:   c0 = 1'b1;
            default: c0 = bus.cin;
        endcase
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg[k] = {1'b0, pa[k][k*SEG +: SEG]} + {1'b0, pb[k][k*SEG +: SEG]}
                   + {{SEG{1'b0}}, pc[k]};
            ns[k]  = ps[k];
            ns[k][k*SEG +: SEG] = seg[k][SEG-1:0];
            nz[k]  = pz[k] & (seg[k][SEG-1:0] == '0);
        end
    end

    // Carry into the MSB recovered from the sum bit and its two operand bits.
    assign c_msb = pa[LAST][MSB] ^ pb[LAST][MSB] ^ ns[LAST][MSB];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) pv[k] <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else if (adv) begin
            pv[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) pv[k] <= pv[k-1];
            out_valid_q <= pv[LAST];
            if (pv[LAST]) begin
                sum_q  <= ns[LAST];
                cout_q <= seg[LAST][SEG];
                ovf_q  <= c_msb ^ seg[LAST][SEG];
                zero_q <= nz[LAST];
                neg_q  <= ns[LAST][MSB];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            pa[0] <= bus.a;
            pb[0] <= bus.op[0] ? ~bus.b : bus.b;
            pc[0] <= c0;
            ps[0] <= '0;
            pz[0] <= 1'b1;
            for (int k = 1; k < STAGES; k++) begin
                pa[k] <= pa[k-1];
                pb[k] <= pb[k-1];
                ps[k] <= ns[k-1];
                pc[k] <= seg[k-1][SEG];
                pz[k] <= nz[k-1];
            end
        end
    end
endmodule
